// File: rtl/mc_control.sv
// mc_control: multicycle control FSM for the RISC-V core.
// Decodes the instruction held in the IR and steps the shared-memory datapath
// one state per clock. It drives the ALU opcode, the datapath mux selects and
// the write strobes.
// Optional feature macro: MC_CTRL_JAL_EN. When it is defined, jal is decoded
// and executed through a dedicated JAL state. When it is undefined, jal is
// treated as illegal and the JAL state does not exist.
module mc_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] aluop,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       adr_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       illegal
);

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;

    // Mux select encodings
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] IMM_I      = 2'b00;
    localparam logic [1:0] IMM_S      = 2'b01;
    localparam logic [1:0] IMM_B      = 2'b10;
`ifdef MC_CTRL_JAL_EN
    localparam logic [1:0] IMM_J      = 2'b11;
`endif

    // Opcodes that the core understands
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MC_CTRL_JAL_EN
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
`ifdef MC_CTRL_JAL_EN
        S_JAL,
`endif
        S_ERROR
    } state_t;

    state_t state_q, state_d;
    logic   illegal_q;

    // Instruction classification. Legality is settled completely here, so
    // the execute states never have to handle an unsupported funct encoding.
    logic is_load, is_store, is_rtype, is_itype, is_beq, is_jal;

    // Classify the instruction currently held in the IR
    always_comb begin
        is_load  = (opcode == OP_LOAD)  && (funct3 == 3'b010);
        is_store = (opcode == OP_STORE) && (funct3 == 3'b010);
        is_beq   = (opcode == OP_BRANCH) && (funct3 == 3'b000);
        is_rtype = 1'b0;
        if (opcode == OP_RTYPE) begin
            case ({funct3, funct7b5})
                4'b0000, 4'b0001, 4'b1110, 4'b1100: is_rtype = 1'b1;
                default:                            is_rtype = 1'b0;
            endcase
        end
        is_itype = (opcode == OP_ITYPE) &&
                   ((funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110));
`ifdef MC_CTRL_JAL_EN
        is_jal = (opcode == OP_JAL);
`else
        is_jal = 1'b0;
`endif
    end

    // State register and the sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == S_ERROR);
        end
    end

    // Next-state logic and Moore outputs. During reset the outputs follow the
    // FETCH state, and every strobe is then forced low.
    always_comb begin
        state_d    = state_q;
        aluop      = ALU_ADD;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        imm_src    = IMM_I;
        adr_src    = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;

        case (rst ? S_FETCH : state_q)
            S_FETCH: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                adr_src    = 1'b0;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
`ifdef MC_CTRL_JAL_EN
                imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
`else
                imm_src   = IMM_B;
`endif
                if (is_load || is_store) state_d = S_MEMADR;
                else if (is_rtype)       state_d = S_EXECR;
                else if (is_itype)       state_d = S_EXECI;
                else if (is_beq)         state_d = S_BEQ;
`ifdef MC_CTRL_JAL_EN
                else if (is_jal)         state_d = S_JAL;
`endif
                else                     state_d = S_ERROR;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                // The write strobe stays up through wait cycles so the
                // memory sees a stable request until it completes.
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                mem_write  = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                if (funct3 == 3'b000)      aluop = funct7b5 ? ALU_SUB : ALU_ADD;
                else if (funct3 == 3'b111) aluop = ALU_AND;
                else                       aluop = ALU_OR;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                if (funct3 == 3'b000)      aluop = ALU_ADD;
                else if (funct3 == 3'b111) aluop = ALU_AND;
                else                       aluop = ALU_OR;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                aluop      = ALU_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
                state_d    = S_FETCH;
            end
`ifdef MC_CTRL_JAL_EN
            S_JAL: begin
                // Jump target was computed in DECODE; the link value
                // OldPC+4 is formed here for ALUWB to write back.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                aluop      = ALU_ADD;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
`endif
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase

        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign illegal = illegal_q & ~rst;

endmodule
